joy_serial_multi: RTL and testbench



---
 rtl/joy_serial_multi.sv | 74 +++++++
 tb/tb_joy_serial_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_multi.sv
// joy_serial_multi: reads a daisy-chained 74HC165 joystick chain and returns
// debounced active-high button vectors, one BITS-wide field per player.
module joy_serial_multi #(
  parameter int NUM_PLAYERS = 2,
  parameter int BITS        = 12,
  parameter int CLK_DIV     = 16,
  parameter int DEBOUNCE    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  output logic                        JOY_CLK,
  output logic                        JOY_LOAD,
  input  logic                        JOY_DATA,
  output logic [NUM_PLAYERS*BITS-1:0] joystick,
  output logic                        frame_done
);
  localparam int TOTAL = NUM_PLAYERS * BITS;
  localparam int BW    = $clog2(TOTAL);
  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, GAP} state_t;
  state_t            state, state_n;
  logic [7:0]        div;
  logic [BW-1:0]     bit_cnt;
  logic [2:0]        db_cnt, db_cnt_n;
  logic [1:0]        sync;
  logic [TOTAL-1:0]  raw, prev, cand;
  logic              tick, last_bit;
  assign tick     = div == 8'(CLK_DIV - 1);
  assign last_bit = bit_cnt == BW'(TOTAL - 1);
  assign cand     = ~raw;
  assign db_cnt_n = cand != prev ? 3'd0 : db_cnt == 3'(DEBOUNCE - 1) ? db_cnt : db_cnt + 3'd1;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = enable ? LOAD : IDLE;
      LOAD:    state_n = tick ? LOW : LOAD;
      LOW:     state_n = tick ? HIGH : LOW;
      HIGH:    state_n = tick ? (last_bit ? GAP : LOW) : HIGH;
      GAP:     state_n = tick ? (enable ? LOAD : IDLE) : GAP;
      default: state_n = IDLE;
    endcase
  end
  // Pins are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      db_cnt     <= '0;
      sync       <= '0;
      raw        <= '0;
      prev       <= '0;
      joystick   <= '0;
      frame_done <= 1'b0;
      JOY_CLK    <= 1'b0;
      JOY_LOAD   <= 1'b1;
    end else begin
      state      <= state_n;
      div        <= (state == IDLE || tick) ? 8'd0 : div + 8'd1;
      sync       <= {sync[0], JOY_DATA};
      JOY_CLK    <= state_n == HIGH;
      JOY_LOAD   <= state_n != LOAD;
      frame_done <= state == GAP && tick;
      if (state == LOAD && tick) bit_cnt <= '0;
      if (state == HIGH && tick && !last_bit) bit_cnt <= bit_cnt + BW'(1);
      if (state == LOW && tick) raw[bit_cnt] <= sync[1];
      if (state == GAP && tick) begin
        db_cnt <= db_cnt_n;
        prev   <= cand;
        if (db_cnt_n == 3'(DEBOUNCE - 1)) joystick <= cand;
      end
    end
  end
endmodule

// File: tb/tb_joy_serial_multi.sv
// tb_joy_serial_multi: drives a behavioural shift-register chain into the reader
// and checks every cycle against a frame-level model of timing and debounce.
module tb_joy_serial_multi;
  localparam int T  = 24;
  localparam int CD = 16;
  localparam int D  = 2;
  localparam int F  = (2 * T + 2) * CD;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, en2 = 1'b0;
  logic jclk, jload, jdata, fd, jclk2, jload2, jdata2, fd2;
  logic [T-1:0]  joy, pat = '0, sr = '1;
  logic [31:0]   joy2, pat2 = '0, sr2 = '1, r2;
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  joy_serial_multi dut (
    .clk(clk), .reset(reset), .enable(enable), .JOY_CLK(jclk), .JOY_LOAD(jload),
    .JOY_DATA(jdata), .joystick(joy), .frame_done(fd)
  );

  joy_serial_multi #(.NUM_PLAYERS(4), .BITS(8), .CLK_DIV(4), .DEBOUNCE(1)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .JOY_CLK(jclk2), .JOY_LOAD(jload2),
    .JOY_DATA(jdata2), .joystick(joy2), .frame_done(fd2)
  );

  // 74HC165 chain: parallel load of active-low buttons, head of chain on the data pin.
  always @(posedge jclk or negedge jload)
    if (!jload) sr <= ~pat;
    else sr <= {1'b1, sr[T-1:1]};
  assign jdata = sr[0];
  always @(posedge jclk2 or negedge jload2)
    if (!jload2) sr2 <= ~pat2;
    else sr2 <= {1'b1, sr2[31:1]};
  assign jdata2 = sr2[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position within the frame, captured pattern, run-length debounce.
  bit          m_act = 1'b0, m_fd = 1'b0;
  int          m_pos = 0, m_run = 1;
  logic [T-1:0] m_pat = '0, m_last = '0, m_joy = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 1'b0; m_pos = 0; m_fd = 1'b0; m_joy = '0; m_last = '0; m_run = 1;
    end else begin
      m_fd = 1'b0;
      if (m_act) begin
        m_pos++;
        if (m_pos == F) begin
          m_fd  = 1'b1;
          m_run = (m_pat == m_last) ? m_run + 1 : 1;
          m_last = m_pat;
          if (m_run >= D) m_joy = m_pat;
          if (enable) begin m_pos = 0; m_pat = pat; end
          else m_act = 1'b0;
        end
      end else if (enable) begin
        m_act = 1'b1; m_pos = 0; m_pat = pat;
      end
    end
  end

  int  q;
  logic e_clk, e_load;
  always @(negedge clk) if (chk_on) begin
    q      = m_pos / CD;
    e_clk  = m_act && q >= 2 && q <= 2 * T && q % 2 == 0;
    e_load = !(m_act && m_pos < CD);
    check("cycle{joy,fd,load,clk}", {5'b0, joy, fd, jload, jclk}, {5'b0, m_joy, m_fd, e_load, e_clk});
  end

  // Runs until the next frame_done; counts the current negedge as part of the frame.
  task automatic run_frame(input bit sel, output int cyc, output int pulses, output int lowc);
    bit pj;
    cyc = 0; pulses = 0;
    lowc = (sel ? jload2 : jload) ? 0 : 1;
    pj = sel ? jclk2 : jclk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (sel ? fd2 : fd) break;
      if ((sel ? jclk2 : jclk) && !pj) pulses++;
      if (!(sel ? jload2 : jload)) lowc++;
      pj = sel ? jclk2 : jclk;
    end
    if (cyc >= 2000) check("frame_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, p, l, lat;
    bit any_clk, any_low, any_fd;
    repeat (4) @(negedge clk);
    #1 reset = 1'b0; chk_on = 1'b1;
    // Wide configuration: 4 players x 8 bits, no debounce.
    pat2 = 32'h8000_0000; en2 = 1'b1;
    run_frame(1, c, p, l);
    check("p3b7_to_bit31", joy2, 32'h8000_0000);
    run_frame(1, c, p, l);
    check("wide_period", 32'(c), 32'd264);
    check("wide_pulses", 32'(p), 32'd32);
    check("wide_load_len", 32'(l), 32'd4);
    #1 r2 = $urandom; pat2 = r2;
    run_frame(1, c, p, l);
    run_frame(1, c, p, l);
    check("wide_random", joy2, r2);
    #1 en2 = 1'b0;
    // Idle chain, continuous frames.
    enable = 1'b1;
    run_frame(0, c, p, l);
    run_frame(0, c, p, l);
    check("period", 32'(c), 32'd800);
    check("pulses", 32'(p), 32'd24);
    check("load_len", 32'(l), 32'd16);
    check("idle_joy", 32'(joy), 32'd0);
    // Pressed pattern appears only on the second matching frame.
    #1 pat = {12'h800, 12'h0A5};
    run_frame(0, c, p, l);
    run_frame(0, c, p, l);
    check("db_frame1", 32'(joy), 32'd0);
    run_frame(0, c, p, l);
    check("db_frame2_p0", 32'(joy[11:0]), 32'h0A5);
    check("db_frame2_p1", 32'(joy[23:12]), 32'h800);
    // Single-frame glitch is filtered.
    #1 pat = 24'h000001;
    run_frame(0, c, p, l);
    run_frame(0, c, p, l);
    run_frame(0, c, p, l);
    check("stable_1", 32'(joy), 32'h1);
    #1 pat = 24'h000003;
    run_frame(0, c, p, l);
    #1 pat = 24'h000001;
    run_frame(0, c, p, l);
    check("glitch_held", 32'(joy), 32'h1);
    run_frame(0, c, p, l);
    check("glitch_after", 32'(joy), 32'h1);
    // Enable dropped during bit 5.
    run_frame(0, c, p, l);
    repeat (11 * CD) @(negedge clk);
    #1 enable = 1'b0;
    run_frame(0, c, p, l);
    any_clk = 0; any_low = 0; any_fd = 0;
    repeat (50) begin
      @(negedge clk);
      any_clk |= jclk; any_low |= !jload; any_fd |= fd;
    end
    check("idle_pins{clk,load_low,fd}", {29'b0, any_clk, any_low, any_fd}, 32'd0);
    #1 enable = 1'b1;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (!jload) break;
    end
    check("reload_latency", 32'(lat), 32'd1);
    // Reset during bit 10 of an all-pressed frame.
    run_frame(0, c, p, l);
    #1 pat = 24'hFFFFFF;
    run_frame(0, c, p, l);
    repeat (21 * CD) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("rst_pins{joy,load,clk}", {6'b0, joy, jload, jclk}, {6'b0, 24'h0, 1'b1, 1'b0});
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    run_frame(0, c, p, l);
    check("post_rst_frame1", 32'(joy), 32'd0);
    run_frame(0, c, p, l);
    check("post_rst_frame2", 32'(joy), 32'hFFFFFF);
    // Random patterns and idle gaps, checked by the per-cycle model.
    for (int i = 0; i < 12; i++) begin
      #1 if ($urandom_range(0, 2) == 0) pat = T'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        run_frame(0, c, p, l);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        #1 enable = 1'b1;
      end
      run_frame(0, c, p, l);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
